// File: rtl/seg_scan_ctrl_pkg.sv
// Shared state encoding and segment constants for the multiplexed
// seven-segment scanner.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_ON  = 2'd1,
      ST_GAP = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-high patterns, bit 6 = segment a ... bit 0 = segment g.
   localparam logic [6:0] PAT_0 = 7'h7E;
   localparam logic [6:0] PAT_1 = 7'h30;
   localparam logic [6:0] PAT_2 = 7'h6D;
   localparam logic [6:0] PAT_3 = 7'h79;
   localparam logic [6:0] PAT_4 = 7'h33;
   localparam logic [6:0] PAT_5 = 7'h5B;
   localparam logic [6:0] PAT_6 = 7'h5F;
   localparam logic [6:0] PAT_7 = 7'h70;
   localparam logic [6:0] PAT_8 = 7'h7F;
   localparam logic [6:0] PAT_9 = 7'h7B;
   localparam logic [6:0] PAT_A = 7'h77;
   localparam logic [6:0] PAT_B = 7'h1F;
   localparam logic [6:0] PAT_C = 7'h4E;
   localparam logic [6:0] PAT_D = 7'h3D;
   localparam logic [6:0] PAT_E = 7'h4F;
   localparam logic [6:0] PAT_F = 7'h47;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-write handshake between a producer and the segment scanner.
interface seg_scan_ctrl_if #(
   parameter int NDIG = 4
);

   logic                wr_valid;
   logic                wr_ready;
   logic [4*NDIG-1:0]   wr_data;
   logic [NDIG-1:0]     wr_blank;

   modport master (
      output wr_valid,
      output wr_data,
      output wr_blank,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      input  wr_blank,
      output wr_ready
   );

endinterface

// File: rtl/seg_scan_ctrl_hex_seg_dec.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
module hex_seg_dec
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_pat
);

   // Nibble lookup; covers all sixteen codes.
   always_comb begin
      o_pat = 7'h00;
      case (i_nib)
         4'h0:    o_pat = PAT_0;
         4'h1:    o_pat = PAT_1;
         4'h2:    o_pat = PAT_2;
         4'h3:    o_pat = PAT_3;
         4'h4:    o_pat = PAT_4;
         4'h5:    o_pat = PAT_5;
         4'h6:    o_pat = PAT_6;
         4'h7:    o_pat = PAT_7;
         4'h8:    o_pat = PAT_8;
         4'h9:    o_pat = PAT_9;
         4'hA:    o_pat = PAT_A;
         4'hB:    o_pat = PAT_B;
         4'hC:    o_pat = PAT_C;
         4'hD:    o_pat = PAT_D;
         4'hE:    o_pat = PAT_E;
         4'hF:    o_pat = PAT_F;
         default: o_pat = 7'h00;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered frame data:
// new frames land in a pending buffer and swap in only at frame boundaries.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NDIG     = 4,
   parameter int PRESCALE = 50000,
   parameter int GAP      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   seg_scan_ctrl_if.slave   wr,
   output logic [6:0]       seg,
   output logic [NDIG-1:0]  an,
   output logic             frame_done
);

   localparam int CW = $clog2((PRESCALE > GAP) ? PRESCALE : GAP);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] ON_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   scan_state_t        r_state;
   scan_state_t        w_state_nxt;
   logic [IW-1:0]      r_idx;
   logic [IW-1:0]      w_idx_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;

   logic [4*NDIG-1:0]  r_act_data;
   logic [NDIG-1:0]    r_act_blank;
   logic [4*NDIG-1:0]  r_pend_data;
   logic [NDIG-1:0]    r_pend_blank;
   logic               r_pend_full;
   logic               r_wr_ready;

   logic [6:0]         r_seg;
   logic [NDIG-1:0]    r_an;
   logic               r_frame_done;

   logic               w_frame_end;
   logic               w_commit;
   logic               w_xfer;
   logic               w_pend_full_nxt;
   logic [4*NDIG-1:0]  w_act_data_nxt;
   logic [NDIG-1:0]    w_act_blank_nxt;
   logic [3:0]         w_nib;
   logic [6:0]         w_pat;
   logic [6:0]         w_seg_nxt;
   logic [NDIG-1:0]    w_an_nxt;
   logic               w_frame_done_nxt;

   // Swap only on the last gap cycle of the last digit, or freely while dark.
   assign w_frame_end     = (r_state == ST_GAP) && (r_idx == IDX_LAST) && (r_cnt == GAP_LAST);
   assign w_commit        = r_pend_full && (w_frame_end || (r_state == ST_OFF));
   assign w_xfer          = wr.wr_valid && r_wr_ready;
   assign w_pend_full_nxt = w_xfer | (r_pend_full & ~w_commit);
   assign w_act_data_nxt  = w_commit ? r_pend_data  : r_act_data;
   assign w_act_blank_nxt = w_commit ? r_pend_blank : r_act_blank;

   // Scan sequencing: OFF -> ON(PRESCALE) -> GAP(GAP) -> next digit.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_OFF: begin
            w_idx_nxt = '0;
            w_cnt_nxt = '0;
            if (en) begin
               w_state_nxt = ST_ON;
            end else begin
               w_state_nxt = ST_OFF;
            end
         end
         ST_ON: begin
            if (!en) begin
               w_state_nxt = ST_OFF;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (r_cnt == ON_LAST) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         ST_GAP: begin
            if (!en) begin
               w_state_nxt = ST_OFF;
               w_idx_nxt   = '0;
               w_cnt_nxt   = '0;
            end else if (r_cnt == GAP_LAST) begin
               w_state_nxt = ST_ON;
               w_cnt_nxt   = '0;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt = '0;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_nib = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];

   hex_seg_dec u_dec (
      .i_nib (w_nib),
      .o_pat (w_pat)
   );

   // Output values for the upcoming cycle, so registered outputs track the state.
   always_comb begin
      w_seg_nxt = SEG_BLANK;
      for (int i = 0; i < NDIG; i++) begin
         w_an_nxt[i] = !((w_state_nxt == ST_ON) && (w_idx_nxt == IW'(i)));
      end
      if ((w_state_nxt == ST_ON) && !w_act_blank_nxt[w_idx_nxt]) begin
         w_seg_nxt = ~w_pat;
      end else begin
         w_seg_nxt = SEG_BLANK;
      end
      w_frame_done_nxt = (w_state_nxt == ST_GAP) && (w_idx_nxt == IDX_LAST) &&
                         (w_cnt_nxt == GAP_LAST);
   end

   // Scan state, digit index and slot counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_OFF;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Pending/active frame buffers and write handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_act_data   <= '0;
         r_act_blank  <= '1;
         r_pend_data  <= '0;
         r_pend_blank <= '0;
         r_pend_full  <= 1'b0;
         r_wr_ready   <= 1'b1;
      end else begin
         r_act_data  <= w_act_data_nxt;
         r_act_blank <= w_act_blank_nxt;
         if (w_xfer) begin
            r_pend_data  <= wr.wr_data;
            r_pend_blank <= wr.wr_blank;
         end
         r_pend_full <= w_pend_full_nxt;
         r_wr_ready  <= ~w_pend_full_nxt;
      end
   end

   // Registered display drive.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seg        <= SEG_BLANK;
         r_an         <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_an         <= w_an_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   assign seg         = r_seg;
   assign an          = r_an;
   assign frame_done  = r_frame_done;
   assign wr.wr_ready = r_wr_ready;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int NDIG     = 4;
   localparam int PRESCALE = 8;
   localparam int GAP      = 2;
   localparam int SLOT     = PRESCALE + GAP;
   localparam int FRAME    = NDIG * SLOT;
   localparam int NCYC     = 5000;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  b;
   } offer_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_done;

   seg_scan_ctrl_if #(.NDIG(NDIG)) wr_if ();

   seg_scan_ctrl #(
      .NDIG     (NDIG),
      .PRESCALE (PRESCALE),
      .GAP      (GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .wr         (wr_if),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   logic [6:0] pat_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int          n_vec = 0;
   int          n_err = 0;

   // Reference model: display running flag plus cycles since scan start.
   bit          m_run;
   int          m_t;
   logic [15:0] m_act_d;
   logic [3:0]  m_act_b;
   logic [15:0] m_pend_d;
   logic [3:0]  m_pend_b;
   bit          m_pend_full;
   bit          m_ready;

   offer_t      offq[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run       = 1'b0;
      m_t         = 0;
      m_act_d     = 16'h0000;
      m_act_b     = 4'hF;
      m_pend_d    = 16'h0000;
      m_pend_b    = 4'h0;
      m_pend_full = 1'b0;
      m_ready     = 1'b1;
   endtask

   task automatic model_step(input logic i_en, input logic i_valid, input logic [15:0] i_d,
                             input logic [3:0] i_b, output bit o_xfer);
      bit fend;
      bit commit;
      fend   = m_run && ((m_t % FRAME) == FRAME - 1);
      commit = m_pend_full && (fend || !m_run);
      o_xfer = i_valid && m_ready;
      if (commit) begin
         m_act_d     = m_pend_d;
         m_act_b     = m_pend_b;
         m_pend_full = 1'b0;
      end
      if (o_xfer) begin
         m_pend_d    = i_d;
         m_pend_b    = i_b;
         m_pend_full = 1'b1;
      end
      m_ready = !m_pend_full;
      if (i_en) begin
         m_t   = m_run ? m_t + 1 : 0;
         m_run = 1'b1;
      end else begin
         m_t   = 0;
         m_run = 1'b0;
      end
   endtask

   task automatic expected(output logic [6:0] e_seg, output logic [3:0] e_an, output logic e_fd);
      int pos;
      int dig;
      e_seg = 7'h7F;
      e_an  = 4'hF;
      e_fd  = 1'b0;
      if (m_run) begin
         pos = m_t % FRAME;
         dig = pos / SLOT;
         if ((pos % SLOT) < PRESCALE) begin
            e_an[dig] = 1'b0;
            e_seg     = m_act_b[dig] ? 7'h7F : ~pat_tbl[m_act_d[dig*4 +: 4]];
         end
         e_fd = (pos == FRAME - 1);
      end
   endtask

   initial begin
      logic [6:0] e_seg;
      logic [3:0] e_an;
      logic       e_fd;
      bit         xfer;
      bit         did_arst;
      int         rst_rel;

      did_arst = 1'b0;
      rst_rel  = 3;
      rst      = 1'b1;
      en       = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = 16'h0000;
      wr_if.wr_blank = 4'h0;
      model_reset();
      #1 rst = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         expected(e_seg, e_an, e_fd);
         check_val("seg", {25'd0, seg}, {25'd0, e_seg});
         check_val("an", {28'd0, an}, {28'd0, e_an});
         check_val("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
         check_val("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, m_ready});

         // Asynchronous reset in the middle of a lit digit.
         if (!did_arst && cyc >= 4000 && m_run && (m_t % SLOT) >= 2 && (m_t % SLOT) <= 5) begin
            did_arst = 1'b1;
            rst_rel  = cyc + 3;
            rst      = 1'b0;
            #1;
            check_val("arst_seg", {25'd0, seg}, 32'h7F);
            check_val("arst_an", {28'd0, an}, 32'hF);
            check_val("arst_frame_done", {31'd0, frame_done}, 32'h0);
            check_val("arst_wr_ready", {31'd0, wr_if.wr_ready}, 32'h1);
         end

         if (cyc < 600) begin
            en = !(cyc >= 548 && cyc < 551);
         end else if (cyc >= 3000 && cyc < 3100) begin
            en = 1'b0;
         end else if (en) begin
            en = ($urandom_range(399, 0) != 0);
         end else begin
            en = ($urandom_range(7, 0) == 0);
         end

         case (cyc)
            100:     offq.push_back('{d: 16'h1234, b: 4'h0});
            300:     offq.push_back('{d: 16'hABCD, b: 4'h0});
            302:     offq.push_back('{d: 16'h0000, b: 4'h0});
            400:     offq.push_back('{d: 16'h8888, b: 4'b0101});
            default: ;
         endcase
         if (cyc >= 600 && offq.size() == 0 && $urandom_range(15, 0) == 0) begin
            offq.push_back('{d: 16'($urandom),
                             b: ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0});
         end

         rst = (cyc >= rst_rel);
         if (offq.size() > 0) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = offq[0].d;
            wr_if.wr_blank = offq[0].b;
         end else begin
            wr_if.wr_valid = 1'b0;
            wr_if.wr_data  = 16'hDEAD;
            wr_if.wr_blank = 4'hA;
         end

         if (!rst) begin
            model_reset();
         end else begin
            model_step(en, wr_if.wr_valid, wr_if.wr_data, wr_if.wr_blank, xfer);
            if (xfer) begin
               void'(offq.pop_front());
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4: number of multiplexed digits.
REQ-002 The block SHALL have parameter PRESCALE, default 50000: clk cycles per digit-on slot, minimum 2.
REQ-003 The block SHALL have parameter GAP, default 4: blanking clk cycles between digits (anti-ghosting), minimum 1.
REQ-004 Port clk  input  1  single clock; all flops rise-edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  1  display enable; low blanks the display.
REQ-007 Port wr_valid  input  1  new frame data offered.
REQ-008 Port wr_ready  output  1  block can accept a frame.
REQ-009 Port wr_data  input  4*NDIG  hex nibbles; nibble i drives digit i.
REQ-010 Port wr_blank  input  NDIG  bit i=1 blanks digit i.
REQ-011 Port seg  output  7  active-low segments {a,b,c,d,e,f,g}, bit 6 = a.
REQ-012 Port an  output  NDIG  active-low digit enables, bit i = digit i.
REQ-013 Port frame_done  output  1  one-cycle pulse at end of each scanned frame.

Function
REQ-014 FSM states SHALL be OFF, ON, GAP; digit index idx 0..NDIG-1; cycle counter cnt.
REQ-015 OFF: seg=7'h7F, an all ones, idx=0, cnt=0; en=1 -> ON next cycle.
REQ-016 ON: an[idx]=0, other an bits 1; seg=~decode(active nibble idx), or 7'h7F if active blank[idx]; stays PRESCALE cycles, then GAP.
REQ-017 GAP: seg=7'h7F, an all ones; stays GAP cycles, then ON with idx+1, wrapping NDIG-1 -> 0.
REQ-018 Last GAP cycle of idx=NDIG-1 SHALL assert frame_done for exactly one cycle.
REQ-019 en low in any state SHALL force OFF on the next clk; outputs blank from that cycle; active/pending registers retained.
REQ-020 Handshake: transfer when wr_valid && wr_ready; data/blank captured into pending register; wr_ready deasserts the following cycle.
REQ-021 Pending SHALL commit to active register only in the frame_done cycle (or any cycle while in OFF); wr_ready reasserts the cycle after commit.
REQ-022 A transfer in the same cycle as commit, with pending empty, SHALL commit at the following frame boundary, never the current one.
REQ-023 Digit content SHALL never change mid-frame (no tearing).
REQ-024 Decoder SHALL map 0-9 and A,b,C,d,E,F; active-high patterns: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B,A=77,b=1F,C=4E,d=3D,E=4F,F=47.
REQ-025 cnt SHALL be $clog2(max(PRESCALE,GAP)) bits, reset to 0 on every state change.

Reset
REQ-026 While rst=0: state=OFF, idx=0, cnt=0, active data=0, active blank=all ones, pending empty, wr_ready=1, seg=7'h7F, an all ones, frame_done=0.
REQ-027 Reset release SHALL take effect on the first clk edge; reset asserted mid-frame SHALL blank outputs immediately (asynchronously).

Structure
REQ-028 Package seg_pkg SHALL hold the state enum, SEG_BLANK=7'h7F, and the 16 decode pattern constants.
REQ-029 Sub-module hex_seg_dec SHALL implement the combinational nibble-to-active-high-pattern decode; the block inverts it.
REQ-030 Outputs seg, an, frame_done SHALL be registered.

Verification (NDIG=4, PRESCALE=8, GAP=2)
REQ-031 Reset, en=1, no write -> all digits blank; frame_done every 40 cycles; an walks E,D,B,7 with 2-cycle F gaps.
REQ-032 Write wr_data=16'h1234, wr_blank=0 -> shown from next frame: digit0 seg=7'b1001100 ('4'), digit3 seg=7'b1001111 ('1'); wr_ready low until commit+1.
REQ-033 Write 16'hABCD mid-frame, then 16'h0000 offered while wr_ready=0 -> second write stalls; ABCD appears whole at next frame, 0000 one frame later.
REQ-034 wr_blank=4'b0101 with 16'h8888 -> digits 0,2 seg=7'h7F with an still pulsed; digits 1,3 seg=7'h00.
REQ-035 en dropped mid-ON of digit 2 -> next cycle seg=7'h7F, an=4'hF; en restored -> scan restarts at digit 0 with prior data.
REQ-036 rst asserted mid-ON -> seg/an blank without clock; after release active blank all ones, wr_ready=1.
